// File: rtl/dbus_translator.sv
// rtl/dbus_translator.sv - data-bus master translating M-stage loads/stores into aligned bus cycles
module dbus_translator (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_En,
  input  logic        i_MemRead_M,
  input  logic        i_MemWrite_M,
  input  logic [2:0]  i_Funct3_M,
  input  logic [31:0] i_Addr_M,
  input  logic [31:0] i_WrData_M,
  output logic        o_BusReq,
  input  logic        i_BusGnt,
  output logic [31:0] o_BusAddr,
  output logic        o_BusWr,
  output logic [3:0]  o_BusByteEn,
  output logic [31:0] o_BusWrData,
  input  logic [31:0] i_BusRdData,
  input  logic        i_BusWaitReq,
  output logic        o_DBusGnt_M,
  output logic        o_DBusWaitReq_W,
  output logic [31:0] o_RdData_W,
  output logic        o_MisalignErr_M
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic [2:0]  capFunct3;
  logic [1:0]  capOffset;
  logic        capWr;
  logic [31:0] rRdData;

  logic        access;
  logic        misaligned;
  logic        busReq;
  logic        accept;
  logic        inData;
  logic        dataDone;
  logic        readDone;
  logic [3:0]  byteEn;
  logic [31:0] wrData;
  logic [31:0] shifted;
  logic [31:0] formatted;

  assign access   = i_MemRead_M | i_MemWrite_M;
  assign inData   = (state == DATA);
  assign dataDone = inData & ~i_BusWaitReq;
  assign readDone = dataDone & ~capWr;

  // Alignment check, lane enables and store-data replication from the M-stage access size
  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b1111;
    wrData     = i_WrData_M;
    case (i_Funct3_M[1:0])
      2'b00: begin
        byteEn = 4'b0001 << i_Addr_M[1:0];
        wrData = {4{i_WrData_M[7:0]}};
      end
      2'b01: begin
        misaligned = i_Addr_M[0];
        byteEn     = i_Addr_M[1] ? 4'b1100 : 4'b0011;
        wrData     = {2{i_WrData_M[15:0]}};
      end
      default: begin
        misaligned = |i_Addr_M[1:0];
      end
    endcase
  end

  // A stalled data phase blocks a new request even if the hazard unit left i_En high;
  // reset forces every output low regardless of the M-stage inputs
  assign busReq = i_Rst_n & i_En & access & ~misaligned & ~(inData & i_BusWaitReq);
  assign accept = busReq & i_BusGnt;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: a completing data phase may overlap a fresh acceptance (back-to-back)
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        if (!i_BusWaitReq) begin
          stateNext = accept ? DATA : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture the access attributes needed to format the returning data phase
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      capFunct3 <= 3'b000;
      capOffset <= 2'b00;
      capWr     <= 1'b0;
    end else if (accept) begin
      capFunct3 <= i_Funct3_M;
      capOffset <= i_Addr_M[1:0];
      capWr     <= i_MemWrite_M;
    end
  end

  assign shifted = i_BusRdData >> {capOffset, 3'b000};

  // Sign/zero extension of the selected lane(s) according to the captured access type
  always_comb begin
    formatted = shifted;
    case (capFunct3)
      3'b000:  formatted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  formatted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  formatted = {24'h000000, shifted[7:0]};
      3'b101:  formatted = {16'h0000, shifted[15:0]};
      default: formatted = shifted;
    endcase
  end

  // Hold the last load result so W sees it until the next read completes
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rRdData <= 32'h0;
    end else if (readDone) begin
      rRdData <= formatted;
    end
  end

  assign o_BusReq        = busReq;
  assign o_BusAddr       = busReq ? {i_Addr_M[31:2], 2'b00} : 32'h0;
  assign o_BusWr         = busReq & i_MemWrite_M;
  assign o_BusByteEn     = busReq ? byteEn : 4'b0000;
  assign o_BusWrData     = (busReq & i_MemWrite_M) ? wrData : 32'h0;
  assign o_DBusGnt_M     = inData | busReq;
  assign o_DBusWaitReq_W = inData & i_BusWaitReq;
  assign o_RdData_W      = readDone ? formatted : rRdData;
  assign o_MisalignErr_M = i_Rst_n & access & misaligned;

endmodule

// File: tb/tb_dbus_translator.sv
// tb/tb_dbus_translator.sv - self-checking bench for dbus_translator
module tb_dbus_translator;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_En;
  logic        i_MemRead_M;
  logic        i_MemWrite_M;
  logic [2:0]  i_Funct3_M;
  logic [31:0] i_Addr_M;
  logic [31:0] i_WrData_M;
  logic        o_BusReq;
  logic        i_BusGnt;
  logic [31:0] o_BusAddr;
  logic        o_BusWr;
  logic [3:0]  o_BusByteEn;
  logic [31:0] o_BusWrData;
  logic [31:0] i_BusRdData;
  logic        i_BusWaitReq;
  logic        o_DBusGnt_M;
  logic        o_DBusWaitReq_W;
  logic [31:0] o_RdData_W;
  logic        o_MisalignErr_M;

  int tests = 0;
  int fails = 0;

  dbus_translator dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_En(i_En),
    .i_MemRead_M(i_MemRead_M), .i_MemWrite_M(i_MemWrite_M),
    .i_Funct3_M(i_Funct3_M), .i_Addr_M(i_Addr_M), .i_WrData_M(i_WrData_M),
    .o_BusReq(o_BusReq), .i_BusGnt(i_BusGnt), .o_BusAddr(o_BusAddr),
    .o_BusWr(o_BusWr), .o_BusByteEn(o_BusByteEn), .o_BusWrData(o_BusWrData),
    .i_BusRdData(i_BusRdData), .i_BusWaitReq(i_BusWaitReq),
    .o_DBusGnt_M(o_DBusGnt_M), .o_DBusWaitReq_W(o_DBusWaitReq_W),
    .o_RdData_W(o_RdData_W), .o_MisalignErr_M(o_MisalignErr_M)
  );

  always #5 i_Clk = ~i_Clk;

  // Access size in bytes from funct3
  function automatic int sizeOf(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // Load result computed arithmetically: extract the addressed bytes, then extend
  function automatic logic [31:0] loadValue(input logic [31:0] data, input logic [2:0] f3, input int off);
    int sz;
    longint v;
    longint span;
    sz   = sizeOf(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(data) >> (8 * off)) % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic setReq(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    i_En = 1'b1; i_BusGnt = 1'b1;
    i_MemRead_M = rd; i_MemWrite_M = wr;
    i_Funct3_M = f3; i_Addr_M = addr; i_WrData_M = wd;
  endtask

  task automatic setIdle();
    i_MemRead_M = 1'b0; i_MemWrite_M = 1'b0; i_BusGnt = 1'b0;
    i_Funct3_M = 3'b010; i_Addr_M = 32'h0; i_WrData_M = 32'h0;
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0; i_BusWaitReq = 1'b0; i_BusRdData = 32'hDEADBEEF;
    setReq(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
    #12;
    tests++; if (o_BusReq !== 1'b0) begin fails++; $display("FAIL reset_busreq got=%b exp=0", o_BusReq); end
    tests++; if (o_BusAddr !== 32'h0) begin fails++; $display("FAIL reset_busaddr got=%h exp=0", o_BusAddr); end
    tests++; if (o_DBusGnt_M !== 1'b0) begin fails++; $display("FAIL reset_gnt got=%b exp=0", o_DBusGnt_M); end
    tests++; if (o_RdData_W !== 32'h0) begin fails++; $display("FAIL reset_rddata got=%h exp=0", o_RdData_W); end
    tests++; if (o_DBusWaitReq_W !== 1'b0) begin fails++; $display("FAIL reset_waitreq got=%b exp=0", o_DBusWaitReq_W); end
    setIdle();
    step();
    i_Rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_byte();
    setReq(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    #2;
    tests++; if (o_BusByteEn !== 4'b1000) begin fails++; $display("FAIL lb_byteen got=%b exp=1000", o_BusByteEn); end
    tests++; if (o_BusAddr !== 32'h0000_1000) begin fails++; $display("FAIL lb_addr got=%h exp=00001000", o_BusAddr); end
    tests++; if (o_BusReq !== 1'b1 || o_BusWr !== 1'b0) begin fails++; $display("FAIL lb_req got=%b%b exp=10", o_BusReq, o_BusWr); end
    step();
    setIdle(); i_BusRdData = 32'h80FF_FFFF;
    #2;
    tests++; if (o_RdData_W !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data got=%h exp=ffffff80", o_RdData_W); end
    tests++; if (o_DBusGnt_M !== 1'b1) begin fails++; $display("FAIL lb_gnt got=%b exp=1", o_DBusGnt_M); end
    step();
    i_BusRdData = 32'h0;
    #2;
    tests++; if (o_RdData_W !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_hold got=%h exp=ffffff80", o_RdData_W); end
    tests++; if (o_DBusGnt_M !== 1'b0) begin fails++; $display("FAIL lb_idle got=%b exp=0", o_DBusGnt_M); end
  endtask

  task automatic test_load_half_unsigned();
    setReq(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0);
    #2;
    tests++; if (o_BusByteEn !== 4'b1100) begin fails++; $display("FAIL lhu_byteen got=%b exp=1100", o_BusByteEn); end
    step();
    setIdle(); i_BusRdData = 32'hBEEF_1234;
    #2;
    tests++; if (o_RdData_W !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_data got=%h exp=0000beef", o_RdData_W); end
    step();
  endtask

  task automatic test_store_byte();
    setReq(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
    #2;
    tests++; if (o_BusWr !== 1'b1) begin fails++; $display("FAIL sb_wr got=%b exp=1", o_BusWr); end
    tests++; if (o_BusByteEn !== 4'b0010) begin fails++; $display("FAIL sb_byteen got=%b exp=0010", o_BusByteEn); end
    tests++; if (o_BusWrData !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wrdata got=%h exp=a5a5a5a5", o_BusWrData); end
    step();
    setIdle(); i_BusRdData = 32'h1234_5678;
    #2;
    tests++; if (o_RdData_W !== 32'h0000_BEEF) begin fails++; $display("FAIL sb_rd_complete got=%h exp=0000beef", o_RdData_W); end
    step();
    #2;
    tests++; if (o_RdData_W !== 32'h0000_BEEF) begin fails++; $display("FAIL sb_rd_after got=%h exp=0000beef", o_RdData_W); end
  endtask

  task automatic test_wait_states();
    int waitCycles;
    waitCycles = 0;
    setReq(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
    step();
    setIdle(); i_BusWaitReq = 1'b1; i_BusRdData = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) setReq(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
      #2;
      if (o_DBusWaitReq_W === 1'b1) waitCycles++;
      tests++; if (o_DBusGnt_M !== 1'b1) begin fails++; $display("FAIL wait_gnt cycle=%0d got=%b exp=1", c, o_DBusGnt_M); end
      tests++; if (o_BusReq !== 1'b0) begin fails++; $display("FAIL wait_blocked cycle=%0d got=%b exp=0", c, o_BusReq); end
      step();
      setIdle();
    end
    i_BusWaitReq = 1'b0;
    #2;
    tests++; if (o_DBusWaitReq_W !== 1'b0) begin fails++; $display("FAIL wait_release got=%b exp=0", o_DBusWaitReq_W); end
    tests++; if (o_RdData_W !== 32'hCAFE_F00D) begin fails++; $display("FAIL wait_data got=%h exp=cafef00d", o_RdData_W); end
    tests++; if (waitCycles != 3) begin fails++; $display("FAIL wait_count got=%0d exp=3", waitCycles); end
    step();
    #2;
    tests++; if (o_DBusGnt_M !== 1'b0) begin fails++; $display("FAIL wait_idle got=%b exp=0", o_DBusGnt_M); end
  endtask

  task automatic test_misalign();
    setReq(1'b1, 1'b0, 3'b001, 32'h0000_4001, 32'h0);
    #2;
    tests++; if (o_MisalignErr_M !== 1'b1) begin fails++; $display("FAIL mis_err got=%b exp=1", o_MisalignErr_M); end
    tests++; if (o_BusReq !== 1'b0) begin fails++; $display("FAIL mis_req got=%b exp=0", o_BusReq); end
    step();
    i_En = 1'b0;
    #2;
    tests++; if (o_MisalignErr_M !== 1'b1) begin fails++; $display("FAIL mis_frozen got=%b exp=1", o_MisalignErr_M); end
    tests++; if (o_DBusGnt_M !== 1'b0) begin fails++; $display("FAIL mis_idle got=%b exp=0", o_DBusGnt_M); end
    setIdle(); i_En = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    setReq(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
    step();
    setReq(1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'h0); i_BusRdData = 32'h1111_2222;
    #2;
    tests++; if (o_RdData_W !== 32'h1111_2222) begin fails++; $display("FAIL b2b_first got=%h exp=11112222", o_RdData_W); end
    tests++; if (o_BusReq !== 1'b1) begin fails++; $display("FAIL b2b_req got=%b exp=1", o_BusReq); end
    step();
    setIdle(); i_BusRdData = 32'h3333_4444;
    #2;
    tests++; if (o_RdData_W !== 32'h3333_4444) begin fails++; $display("FAIL b2b_second got=%h exp=33334444", o_RdData_W); end
    tests++; if (o_DBusGnt_M !== 1'b1) begin fails++; $display("FAIL b2b_gnt got=%b exp=1", o_DBusGnt_M); end
    step();
    #2;
    tests++; if (o_DBusGnt_M !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%b exp=0", o_DBusGnt_M); end
  endtask

  task automatic test_async_reset();
    setReq(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0);
    step();
    i_BusWaitReq = 1'b1; i_BusRdData = 32'h5555_AAAA;
    #2;
    tests++; if (o_DBusWaitReq_W !== 1'b1) begin fails++; $display("FAIL arst_pre got=%b exp=1", o_DBusWaitReq_W); end
    i_Rst_n = 1'b0;
    #1;
    tests++; if (o_DBusWaitReq_W !== 1'b0 || o_DBusGnt_M !== 1'b0 || o_BusReq !== 1'b0)
      begin fails++; $display("FAIL arst_ctrl got=%b%b%b exp=000", o_DBusWaitReq_W, o_DBusGnt_M, o_BusReq); end
    tests++; if (o_RdData_W !== 32'h0) begin fails++; $display("FAIL arst_data got=%h exp=0", o_RdData_W); end
    step();
    setIdle(); i_Rst_n = 1'b1;
    #2;
    tests++; if (o_DBusWaitReq_W !== 1'b0 || o_DBusGnt_M !== 1'b0)
      begin fails++; $display("FAIL arst_release got=%b%b exp=00", o_DBusWaitReq_W, o_DBusGnt_M); end
    i_BusWaitReq = 1'b0;
    step();
    #2;
    tests++; if (o_RdData_W !== 32'h0) begin fails++; $display("FAIL arst_no_completion got=%h exp=0", o_RdData_W); end
  endtask

  task automatic test_random();
    bit          mPending = 1'b0;
    logic [2:0]  mF3 = 3'b0;
    int          mOff = 0;
    bit          mWr = 1'b0;
    logic [31:0] mStored = 32'h0;
    logic [2:0]  f3List [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 400; n++) begin
      int op, sz, off;
      bit acc, mis, expReq;
      logic [31:0] expAddr, expWd, expRd, curFmt;
      logic [3:0]  expBe;
      op = $urandom_range(0, 3);
      i_MemRead_M  = (op == 1 || op == 3);
      i_MemWrite_M = (op == 2);
      i_Funct3_M   = i_MemWrite_M ? f3List[$urandom_range(0, 2)] : f3List[$urandom_range(0, 4)];
      i_Addr_M     = $urandom;
      if ($urandom_range(0, 9) < 7) i_Addr_M = i_Addr_M & ~(32'(sizeOf(i_Funct3_M)) - 32'd1);
      i_WrData_M   = $urandom;
      i_En         = ($urandom_range(0, 7) != 0);
      i_BusGnt     = ($urandom_range(0, 3) != 0);
      i_BusWaitReq = ($urandom_range(0, 2) == 0);
      i_BusRdData  = $urandom;
      #2;
      sz     = sizeOf(i_Funct3_M);
      off    = int'(i_Addr_M % 4);
      acc    = i_MemRead_M || i_MemWrite_M;
      mis    = acc && ((i_Addr_M % sz) != 0);
      expReq = i_En && acc && !mis && !(mPending && i_BusWaitReq);
      expAddr = expReq ? (i_Addr_M / 4) * 4 : 32'h0;
      expBe   = expReq ? 4'(((1 << sz) - 1) << off) : 4'h0;
      if (sz == 1)      expWd = (i_WrData_M % 256) * 32'h0101_0101;
      else if (sz == 2) expWd = (i_WrData_M % 65536) * 32'h0001_0001;
      else              expWd = i_WrData_M;
      if (!(expReq && i_MemWrite_M)) expWd = 32'h0;
      curFmt = loadValue(i_BusRdData, mF3, mOff);
      expRd  = (mPending && !i_BusWaitReq && !mWr) ? curFmt : mStored;
      tests++; if (o_BusReq !== expReq) begin fails++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, o_BusReq, expReq); end
      tests++; if (o_MisalignErr_M !== mis) begin fails++; $display("FAIL rnd_mis n=%0d got=%b exp=%b", n, o_MisalignErr_M, mis); end
      tests++; if (o_BusAddr !== expAddr) begin fails++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, o_BusAddr, expAddr); end
      tests++; if (o_BusByteEn !== expBe) begin fails++; $display("FAIL rnd_be n=%0d got=%b exp=%b", n, o_BusByteEn, expBe); end
      tests++; if (o_BusWr !== (expReq && i_MemWrite_M)) begin fails++; $display("FAIL rnd_wr n=%0d got=%b", n, o_BusWr); end
      tests++; if (o_BusWrData !== expWd) begin fails++; $display("FAIL rnd_wd n=%0d got=%h exp=%h", n, o_BusWrData, expWd); end
      tests++; if (o_DBusGnt_M !== (mPending || expReq)) begin fails++; $display("FAIL rnd_gnt n=%0d got=%b", n, o_DBusGnt_M); end
      tests++; if (o_DBusWaitReq_W !== (mPending && i_BusWaitReq)) begin fails++; $display("FAIL rnd_wait n=%0d got=%b", n, o_DBusWaitReq_W); end
      tests++; if (o_RdData_W !== expRd) begin fails++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, o_RdData_W, expRd); end
      if (mPending && !i_BusWaitReq) begin
        if (!mWr) mStored = curFmt;
        mPending = 1'b0;
      end
      if (expReq && i_BusGnt) begin
        mPending = 1'b1; mF3 = i_Funct3_M; mOff = off; mWr = i_MemWrite_M;
      end
      step();
    end
    setIdle(); i_BusWaitReq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half_unsigned();
    test_store_byte();
    test_wait_states();
    test_misalign();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbus_translator.md
# dbus_translator

Data-bus master for the CPU's M/W stages: turns load/store requests from the M stage into word-aligned bus transactions with byte enables, then sign- or zero-extends the read data returned during W. It sits directly downstream of the hazard unit: it consumes that unit's translator-enable signal and produces the grant and wait-request signals the hazard unit uses to freeze the pipeline.

## Interface
- (no parameters; address and data are fixed at 32 bits)
- i_Clk  in  1  system clock; all state updates on the rising edge
- i_Rst_n  in  1  reset; asynchronous, active-low
- i_En  in  1  translator enable from the hazard unit; 0 = freeze
- i_MemRead_M  in  1  load in M
- i_MemWrite_M  in  1  store in M
- i_Funct3_M  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_Addr_M  in  32  byte address
- i_WrData_M  in  32  store data, right-aligned
- o_BusReq  out  1  request the bus for the address phase
- i_BusGnt  in  1  arbiter grant
- o_BusAddr  out  32  {i_Addr_M[31:2], 2'b00}
- o_BusWr  out  1  1 = write
- o_BusByteEn  out  4  lane enables
- o_BusWrData  out  32  lane-replicated store data
- i_BusRdData  in  32  read data, valid when the data phase completes
- i_BusWaitReq  in  1  slave is not ready; extends the data phase
- o_DBusGnt_M  out  1  to hazard unit: an access is pending in M or outstanding in W
- o_DBusWaitReq_W  out  1  to hazard unit: the W data phase is stalled
- o_RdData_W  out  32  formatted load result
- o_MisalignErr_M  out  1  misaligned access in M; no bus cycle is issued

## Operation
- **Alignment check:**
  - Half-word access is misaligned when addr[0]=1.
  - Word access is misaligned when addr[1:0]≠0.
  - A misaligned access asserts o_MisalignErr_M combinationally while it is in M. o_BusReq stays 0 for it.
- **Request:** o_BusReq = i_En & (i_MemRead_M | i_MemWrite_M) & ~misaligned.
  - o_BusAddr, o_BusWr, o_BusByteEn and o_BusWrData are valid whenever o_BusReq=1.
  - They are 0 when o_BusReq=0.
- **Byte enables:**
  - Byte access: 0001 << addr[1:0].
  - Half-word access: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word access: 1111.
- **Write data:**
  - SB replicates the byte into all four lanes.
  - SH replicates the half-word into both halves.
  - SW passes the word through.
- **Address-phase acceptance:** the address phase is accepted when o_BusReq & i_BusGnt at a rising edge. On acceptance the block captures funct3, addr[1:0] and the write flag, and enters DATA.
- **FSM states:**
  - IDLE: no transaction outstanding.
  - DATA: one transaction is outstanding.
- **FSM transitions:**
  - IDLE→DATA on acceptance.
  - DATA→IDLE when i_BusWaitReq=0 and there is no new acceptance in that cycle.
  - DATA→DATA, back-to-back, when i_BusWaitReq=0 and a new acceptance happens in the same cycle. The capture registers are overwritten.
  - While DATA and i_BusWaitReq=1, the state holds. A new acceptance cannot occur because the hazard unit deasserts i_En. If i_En=1 anyway, the request is still blocked: o_BusReq is gated by ~(DATA & i_BusWaitReq).
- **Wait request:** o_DBusWaitReq_W = DATA & i_BusWaitReq.
- **Pending/outstanding flag:** o_DBusGnt_M = DATA | o_BusReq.
- **Read formatting**, applied on completion of a read (DATA & ~i_BusWaitReq & ~captured write flag):
  - Shift i_BusRdData right by 8×offset.
  - Sign-extend for B/H, zero-extend for BU/HU, pass through for W.
- **o_RdData_W:**
  - In the completion cycle it is the formatted live value.
  - At the same edge that value is stored in r_RdData.
  - In every other cycle o_RdData_W = r_RdData.
- **Writes:** completion of a write leaves r_RdData unchanged.
- **Freeze:** i_En=0 gates new requests only. An outstanding DATA phase keeps sampling i_BusWaitReq and completes normally.

## Timing
- Reset (async, i_Rst_n=0):
  - State goes to IDLE; capture registers and r_RdData go to 0.
  - All outputs are 0, including o_RdData_W.
  - An outstanding transaction is abandoned; no completion is reported after reset releases.
- Address phase: 0-cycle combinational request. Acceptance occurs at the edge where i_BusGnt=1.
- Load latency: with i_BusWaitReq=0, data appears on o_RdData_W in the cycle after acceptance (the W cycle).
- Each i_BusWaitReq=1 cycle in DATA adds one cycle. o_DBusWaitReq_W follows i_BusWaitReq combinationally.
- No grant: o_BusReq stays high and nothing is captured. The access stays in M until granted.
- Misaligned access combined with i_En=0: o_MisalignErr_M is still reported, since it depends only on the M inputs.

## Test plan
- LB at addr 0x1003, bus returns 0x80FF_FF_FF with no wait:
  - o_BusByteEn=1000 and o_BusAddr=0x1000.
  - In the next cycle o_RdData_W=0xFFFF_FF80.
- LHU at addr 0x2002, bus returns 0xBEEF_1234:
  - o_BusByteEn=1100.
  - o_RdData_W=0x0000_BEEF.
- SB of 0x0000_00A5 at addr 0x3001:
  - o_BusWr=1, o_BusByteEn=0010, o_BusWrData=0xA5A5_A5A5.
  - r_RdData is unchanged.
- LW with i_BusWaitReq high for 3 cycles:
  - o_DBusWaitReq_W=1 for exactly 3 cycles.
  - o_DBusGnt_M=1 throughout.
  - Data is valid in the 4th cycle, and the state returns to IDLE.
- LH at addr 0x4001:
  - o_MisalignErr_M=1 and o_BusReq=0.
  - The state stays IDLE.
- Back-to-back LW/LW with no wait states: the second acceptance occurs on the first one's completion edge and both results appear on consecutive cycles.
- Async reset asserted while in DATA with i_BusWaitReq=1:
  - All outputs drop to 0 immediately.
  - After release the state is IDLE and o_DBusWaitReq_W=0.
